instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch/load-store front end sitting directly upstream of the CPU controller FSM and datapath. It sits between them and the shared RAM/IO bus.
- Owns the program counter `PC` and the instruction register.
- Arbitrates the single memory port between instruction fetch and LDR/STR data accesses, and implements HALT freeze.
- `PC` follows the architectural rule: it holds N+1 before the instruction at address N executes.

Parameters:
- PC_W, 9: program counter and memory address width.
- DATA_W, 16: instruction and memory data width.
- MEM_LAT, 1: cycles from address/read-command presented to mem_rdata valid (1..4).

Ports:
- clk  in  1  rising-edge clock (KEY[0]-derived at top level).
- reset  in  1  asynchronous, active-low reset (wired directly from KEY[1]).
- mem_cmd  out  2  bus command: NONE / READ / WRITE.
- mem_addr  out  PC_W  bus address.
- mem_rdata  in  DATA_W  read data from RAM/IO mux.
- ir  out  DATA_W  current instruction, stable while ir_valid.
- ir_valid  out  1  ir holds an instruction under execution.
- ir_ready  in  1  controller retires the current instruction; fetch the next one.
- ls_req  in  1  controller requests a data access (single-cycle pulse).
- ls_write  in  1  1 = STR, 0 = LDR; sampled with ls_req.
- ls_addr  in  PC_W  data address; sampled with ls_req.
- ls_done  out  1  one-cycle pulse. For LDR, mem_rdata is valid in this same cycle.
- pc_load  in  1  branch: replace PC with pc_target and retire.
- pc_target  in  PC_W  branch target.
- halt  in  1  HALT decoded.
- halted  out  1  unit frozen.
- PC  out  PC_W  program counter (register named PC).

Behaviour:
- Reset (async, reset=0):
  - State S_RST; PC=0; ir=0; ir_valid=0; ls_done=0; halted=0; mem_cmd=NONE; mem_addr=0.
  - A reset mid-fetch or mid-LS abandons the access; no partial IR update.
- S_RST: one cycle after reset deasserts (PC held 0), then S_FETCH.
- S_FETCH:
  - Drive mem_cmd=READ, mem_addr=PC.
  - Latency counter = MEM_LAT-1; go to S_WAIT. With MEM_LAT=1, S_WAIT lasts one cycle.
- S_WAIT:
  - Hold READ/addr while counter>0.
  - When data is valid: ir<=mem_rdata, PC<=PC+1 (modulo 2^PC_W, 511 wraps to 0), ir_valid<=1, go to S_EXEC.
- S_EXEC (ir_valid=1, mem_cmd=NONE, mem_addr=PC). Per-cycle priority:
  1. halt: S_HALT.
  2. pc_load: PC<=pc_target, ir_valid<=0, go to S_FETCH. Any simultaneous ir_ready/ls_req is ignored.
  3. ls_req: latch ls_write/ls_addr, go to S_LS. A simultaneous ir_ready is ignored and must be reasserted.
  4. ir_ready: ir_valid<=0, go to S_FETCH.
- S_LS (ir and ir_valid held):
  - mem_addr=latched ls_addr.
  - STR: mem_cmd=WRITE for exactly one cycle, then ls_done=1 for the next cycle, return to S_EXEC.
  - LDR: mem_cmd=READ held for MEM_LAT cycles; ls_done=1 in the cycle rdata is valid; return to S_EXEC.
  - ls_req/ir_ready/pc_load are ignored while in S_LS.
- S_HALT: halted=1, mem_cmd=NONE, PC and ir frozen. Only reset exits.
- ls_done is never asserted outside the single completion cycle.
- mem_cmd is never WRITE during fetch.

Decomposition:
- Package cpu_pkg: mem_cmd encodings MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10; fetch state enum (S_RST, S_FETCH, S_WAIT, S_EXEC, S_LS, S_HALT); PC_W/DATA_W defaults.
- One sub-module: pc_reg. It holds PC with async active-low reset, load-increment-or-target mux and wrap.
- The FSM, latency counter and bus mux stay in instr_fetch_unit.

Test Plan:
- Reset/first fetch: assert reset low for 10 ns, release, RAM[0]=16'hD00A, MEM_LAT=1 → PC=0 in S_RST; PC goes 0→1 in the same cycle ir=16'hD00A and ir_valid=1; mem_cmd=READ to addr 0 exactly once.
- Retire sequence: pulse ir_ready three times, RAM[1..3] distinct → PC steps 2,3,4; ir matches RAM[1..3]; no fetch while ir_valid=1 without ir_ready.
- LDR/STR: ls_req with ls_write=0, ls_addr=10, RAM[10]=16'hABCD → one READ to 10, ls_done coincident with rdata=ABCD. Then ls_write=1, ls_addr=11 → exactly one WRITE cycle at 11, ls_done next cycle; PC unchanged.
- Priority/collision: ls_req and ir_ready in the same cycle → LS performed and no fetch. Branch with pc_load=1, pc_target=9'h1FF alongside ir_ready → next fetch from 0x1FF, PC becomes 0 (wrap).
- Halt: halt=1 in S_EXEC at PC=10 → halted=1, PC stays 10 and mem_cmd=NONE for 50 cycles regardless of ir_ready/ls_req.
- Latency/reset mid-op: MEM_LAT=3 → READ held 3 cycles before capture. Reset pulled low during S_WAIT → PC=0, ir_valid=0 immediately (async); clean refetch from 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the CPU front end: bus commands,
// fetch-unit states and default widths.
package cpu_pkg;

    localparam int PC_W_DEF   = 9;
    localparam int DATA_W_DEF = 16;

    // Wide enough to count up to the longest supported memory latency (4).
    localparam int LAT_CNT_W  = 3;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_LS,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: holds its value, steps by one (wrapping at
// 2^PC_W) or loads a branch target. Load wins over increment.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/load-store front end: owns PC and IR, shares the single memory port
// between instruction fetch and LDR/STR, and freezes on HALT.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        mem_cmd,
    output logic [PC_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [PC_W-1:0]   ls_addr,
    output logic              ls_done,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   pc_target,
    input  logic              halt,
    output logic              halted,
    output logic [PC_W-1:0]   PC
);

    fetch_state_e          state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]     ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  ls_write_q, ls_write_d;
    logic [PC_W-1:0]       ls_addr_q, ls_addr_d;
    logic                  pc_inc;
    logic                  pc_ld;

    pc_reg #(
        .PC_W (PC_W)
    ) u_pc_reg (
        .clk_i    (clk),
        .rst_ni   (reset),
        .inc_i    (pc_inc),
        .load_i   (pc_ld),
        .target_i (pc_target),
        .pc_o     (PC)
    );

    // The counter drives the bus command: non-zero means the access is still
    // on the bus, zero means the data (or write completion) is due this cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ls_write_d = ls_write_q;
        ls_addr_d  = ls_addr_q;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        mem_cmd    = MNONE;
        mem_addr   = PC;
        ls_done    = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_cmd = MREAD;
                cnt_d   = LAT_CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    mem_cmd = MREAD;
                    cnt_d   = cnt_q - LAT_CNT_W'(1);
                end else begin
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    pc_inc     = 1'b1;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (pc_load) begin
                    pc_ld      = 1'b1;
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (ls_req) begin
                    ls_write_d = ls_write;
                    ls_addr_d  = ls_addr;
                    cnt_d      = ls_write ? LAT_CNT_W'(1) : LAT_CNT_W'(MEM_LAT);
                    state_d    = S_LS;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_LS: begin
                mem_addr = ls_addr_q;
                if (cnt_q != '0) begin
                    mem_cmd = ls_write_q ? MWRITE : MREAD;
                    cnt_d   = cnt_q - LAT_CNT_W'(1);
                end else begin
                    ls_done = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RST;
            cnt_q      <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            ls_write_q <= 1'b0;
            ls_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ls_write_q <= ls_write_d;
            ls_addr_q  <= ls_addr_d;
        end
    end

    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: one instance at MEM_LAT=1 for the
// functional sequence, one at MEM_LAT=3 for latency and mid-fetch reset.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [15:0] ir;
        logic [8:0]  addr;
        logic [8:0]  pc;
    } fetchExp_t;

    typedef struct packed {
        logic        write;
        logic [8:0]  addr;
        logic [15:0] data;
    } lsExp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int totalChecks = 0;
    int passChecks  = 0;

    logic [15:0] ram [512];

    // DUT A: MEM_LAT = 1
    logic        rstA;
    logic [1:0]  memCmdA;
    logic [8:0]  memAddrA;
    logic [15:0] memRdataA;
    logic [15:0] irA;
    logic        irValidA, irReadyA, lsReqA, lsWriteA, lsDoneA;
    logic [8:0]  lsAddrA, pcTargetA, pcA;
    logic        pcLoadA, haltA, haltedA;

    // DUT B: MEM_LAT = 3
    logic        rstB;
    logic [1:0]  memCmdB;
    logic [8:0]  memAddrB;
    logic [15:0] memRdataB;
    logic [15:0] irB;
    logic        irValidB, irReadyB, lsDoneB, haltedB;
    logic [8:0]  pcB;

    instr_fetch_unit #(.PC_W(9), .DATA_W(16), .MEM_LAT(1)) dutA (
        .clk(clk), .reset(rstA), .mem_cmd(memCmdA), .mem_addr(memAddrA),
        .mem_rdata(memRdataA), .ir(irA), .ir_valid(irValidA), .ir_ready(irReadyA),
        .ls_req(lsReqA), .ls_write(lsWriteA), .ls_addr(lsAddrA), .ls_done(lsDoneA),
        .pc_load(pcLoadA), .pc_target(pcTargetA), .halt(haltA), .halted(haltedA),
        .PC(pcA)
    );

    instr_fetch_unit #(.PC_W(9), .DATA_W(16), .MEM_LAT(3)) dutB (
        .clk(clk), .reset(rstB), .mem_cmd(memCmdB), .mem_addr(memAddrB),
        .mem_rdata(memRdataB), .ir(irB), .ir_valid(irValidB), .ir_ready(irReadyB),
        .ls_req(1'b0), .ls_write(1'b0), .ls_addr(9'd0), .ls_done(lsDoneB),
        .pc_load(1'b0), .pc_target(9'd0), .halt(1'b0), .halted(haltedB),
        .PC(pcB)
    );

    // Synchronous RAM models: read data appears MEM_LAT cycles after the address.
    logic [8:0] pipeA;
    logic [8:0] pipeB [3];
    always @(posedge clk) begin
        pipeA    <= memAddrA;
        pipeB[0] <= memAddrB;
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign memRdataA = ram[pipeA];
    assign memRdataB = ram[pipeB[2]];

    fetchExp_t fetchQA[$];
    fetchExp_t fetchQB[$];
    lsExp_t    lsQA[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failEvent(input string name);
        totalChecks++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Monitor A: tracks bus activity and checks every fetch capture and LS completion.
    int   cycA = 0;
    int   readRunA = 0, lastReadRunA = 0, writeCountA = 0, writeCycleA = 0;
    logic [8:0] readAddrA = '0, writeAddrA = '0;
    logic prevIrValidA = 1'b0;
    always @(negedge clk) begin
        fetchExp_t fe;
        lsExp_t    le;
        cycA++;
        if (memCmdA == MREAD) begin
            readRunA++;
            readAddrA = memAddrA;
        end else if (readRunA != 0) begin
            lastReadRunA = readRunA;
            readRunA = 0;
        end
        if (memCmdA == MWRITE) begin
            writeCountA++;
            writeAddrA  = memAddrA;
            writeCycleA = cycA;
        end
        if (irValidA && !prevIrValidA) begin
            if (fetchQA.size() == 0) begin
                failEvent("A_unexpected_fetch");
            end else begin
                fe = fetchQA.pop_front();
                checkOutput("A_fetch_ir", 32'(irA), 32'(fe.ir));
                checkOutput("A_fetch_pc", 32'(pcA), 32'(fe.pc));
                checkOutput("A_fetch_addr", 32'(readAddrA), 32'(fe.addr));
                checkOutput("A_fetch_read_cycles", 32'(lastReadRunA), 32'd1);
            end
        end
        prevIrValidA = irValidA;
        if (lsDoneA) begin
            if (lsQA.size() == 0) begin
                failEvent("A_unexpected_ls_done");
            end else begin
                le = lsQA.pop_front();
                checkOutput("A_ls_addr", 32'(memAddrA), 32'(le.addr));
                if (le.write) begin
                    checkOutput("A_str_write_addr", 32'(writeAddrA), 32'(le.addr));
                    checkOutput("A_str_write_cycles", 32'(writeCountA), 32'd1);
                    checkOutput("A_str_done_delay", 32'(cycA - writeCycleA), 32'd1);
                end else begin
                    checkOutput("A_ldr_rdata", 32'(memRdataA), 32'(le.data));
                    checkOutput("A_ldr_read_addr", 32'(readAddrA), 32'(le.addr));
                    checkOutput("A_ldr_read_cycles", 32'(lastReadRunA), 32'd1);
                end
            end
        end
    end

    // Monitor B: fetch captures at MEM_LAT = 3.
    int   readRunB = 0, lastReadRunB = 0;
    logic [8:0] readAddrB = '0;
    logic prevIrValidB = 1'b0;
    always @(negedge clk) begin
        fetchExp_t fe;
        if (memCmdB == MREAD) begin
            readRunB++;
            readAddrB = memAddrB;
        end else if (readRunB != 0) begin
            lastReadRunB = readRunB;
            readRunB = 0;
        end
        if (irValidB && !prevIrValidB) begin
            if (fetchQB.size() == 0) begin
                failEvent("B_unexpected_fetch");
            end else begin
                fe = fetchQB.pop_front();
                checkOutput("B_fetch_ir", 32'(irB), 32'(fe.ir));
                checkOutput("B_fetch_pc", 32'(pcB), 32'(fe.pc));
                checkOutput("B_fetch_addr", 32'(readAddrB), 32'(fe.addr));
                checkOutput("B_fetch_read_cycles", 32'(lastReadRunB), 32'd3);
            end
        end
        prevIrValidB = irValidB;
    end

    // One-cycle pulse on DUT A's controller inputs.
    task automatic applyStimulus(input logic rdy, input logic req, input logic wr,
                                 input logic [8:0] addr, input logic ld,
                                 input logic [8:0] tgt, input logic hlt);
        @(posedge clk);
        #1;
        irReadyA = rdy; lsReqA = req; lsWriteA = wr; lsAddrA = addr;
        pcLoadA = ld; pcTargetA = tgt; haltA = hlt;
        @(posedge clk);
        #1;
        irReadyA = 1'b0; lsReqA = 1'b0; lsWriteA = 1'b0; lsAddrA = '0;
        pcLoadA = 1'b0; pcTargetA = '0; haltA = 1'b0;
    endtask

    // which: 0 = A ir_valid, 1 = A ls_done, 2 = B ir_valid
    task automatic waitFor(input int which, input int budget, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && irValidA) || (which == 1 && lsDoneA) ||
                (which == 2 && irValidB)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) failEvent({name, "_timeout"});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    logic [15:0] retireIr [3];
    int badCycles;

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        ram[0]   = 16'hD00A;
        ram[1]   = 16'h1111;
        ram[2]   = 16'h2222;
        ram[3]   = 16'h3333;
        ram[9]   = 16'h9999;
        ram[10]  = 16'hABCD;
        ram[511] = 16'h7E57;
        retireIr[0] = 16'h1111;
        retireIr[1] = 16'h2222;
        retireIr[2] = 16'h3333;

        rstA = 1'b0; rstB = 1'b0; irReadyB = 1'b0;
        irReadyA = 1'b0; lsReqA = 1'b0; lsWriteA = 1'b0; lsAddrA = '0;
        pcLoadA = 1'b0; pcTargetA = '0; haltA = 1'b0;

        #9;
        checkOutput("rst_pc", 32'(pcA), 32'd0);
        checkOutput("rst_ir", 32'(irA), 32'd0);
        checkOutput("rst_ir_valid", 32'(irValidA), 32'd0);
        checkOutput("rst_mem_cmd", 32'(memCmdA), 32'(MNONE));
        checkOutput("rst_mem_addr", 32'(memAddrA), 32'd0);
        checkOutput("rst_ls_done", 32'(lsDoneA), 32'd0);
        checkOutput("rst_halted", 32'(haltedA), 32'd0);

        fetchQA.push_back('{ir: 16'hD00A, addr: 9'd0, pc: 9'd1});
        #3 rstA = 1'b1;
        #1;
        checkOutput("srst_pc_held", 32'(pcA), 32'd0);
        checkOutput("srst_mem_cmd", 32'(memCmdA), 32'(MNONE));
        waitFor(0, 20, "first_fetch");

        repeat (5) @(negedge clk);
        checkOutput("idle_no_fetch_cmd", 32'(memCmdA), 32'(MNONE));
        checkOutput("idle_pc_held", 32'(pcA), 32'd1);

        for (int k = 0; k < 3; k++) begin
            fetchQA.push_back('{ir: retireIr[k], addr: 9'(k + 1), pc: 9'(k + 2)});
            applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0);
            waitFor(0, 20, "retire_fetch");
        end

        lsQA.push_back('{write: 1'b0, addr: 9'd10, data: 16'hABCD});
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd10, 1'b0, 9'd0, 1'b0);
        waitFor(1, 20, "ldr_done");

        lsQA.push_back('{write: 1'b1, addr: 9'd11, data: 16'h0000});
        applyStimulus(1'b0, 1'b1, 1'b1, 9'd11, 1'b0, 9'd0, 1'b0);
        waitFor(1, 20, "str_done");
        @(negedge clk);
        checkOutput("pc_after_ls", 32'(pcA), 32'd4);
        checkOutput("ls_done_single_cycle", 32'(lsDoneA), 32'd0);

        lsQA.push_back('{write: 1'b0, addr: 9'd3, data: 16'h3333});
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd3, 1'b0, 9'd0, 1'b0);
        waitFor(1, 20, "collide_ldr_done");
        repeat (3) @(negedge clk);
        checkOutput("collide_ir_valid", 32'(irValidA), 32'd1);
        checkOutput("collide_pc", 32'(pcA), 32'd4);
        checkOutput("collide_no_fetch", 32'(memCmdA), 32'(MNONE));

        fetchQA.push_back('{ir: 16'h7E57, addr: 9'h1FF, pc: 9'd0});
        applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 9'h1FF, 1'b0);
        waitFor(0, 20, "branch_wrap_fetch");

        fetchQA.push_back('{ir: 16'h9999, addr: 9'd9, pc: 9'd10});
        applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 9'd9, 1'b0);
        waitFor(0, 20, "branch_9_fetch");

        applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b1);
        @(negedge clk);
        checkOutput("halted", 32'(haltedA), 32'd1);
        badCycles = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            irReadyA = 1'b1;
            lsReqA   = c[0];
            lsAddrA  = 9'd10;
            @(negedge clk);
            if (!haltedA || pcA !== 9'd10 || memCmdA !== MNONE || lsDoneA || irA !== 16'h9999)
                badCycles++;
        end
        irReadyA = 1'b0; lsReqA = 1'b0; lsAddrA = '0;
        checkOutput("halt_frozen_bad_cycles", 32'(badCycles), 32'd0);

        fetchQB.push_back('{ir: 16'hD00A, addr: 9'd0, pc: 9'd1});
        @(negedge clk);
        #2 rstB = 1'b1;
        waitFor(2, 30, "B_first_fetch");

        @(posedge clk);
        #1 irReadyB = 1'b1;
        @(posedge clk);
        #1 irReadyB = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("B_mid_wait_cmd", 32'(memCmdB), 32'(MREAD));
        checkOutput("B_mid_wait_pc", 32'(pcB), 32'd1);
        rstB = 1'b0;
        #1;
        checkOutput("B_async_rst_pc", 32'(pcB), 32'd0);
        checkOutput("B_async_rst_ir_valid", 32'(irValidB), 32'd0);
        checkOutput("B_async_rst_cmd", 32'(memCmdB), 32'(MNONE));
        fetchQB.push_back('{ir: 16'hD00A, addr: 9'd0, pc: 9'd1});
        #2 rstB = 1'b1;
        waitFor(2, 30, "B_refetch");

        repeat (2) @(negedge clk);
        checkOutput("fetchQA_drained", 32'(fetchQA.size()), 32'd0);
        checkOutput("lsQA_drained", 32'(lsQA.size()), 32'd0);
        checkOutput("fetchQB_drained", 32'(fetchQB.size()), 32'd0);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
